// File: rtl/ram_bist_pkg.sv
// Shared types and helpers for the RAM BIST controller.
package ram_bist_pkg;

  localparam int unsigned ADDR_W_DEF    = 10;
  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned MEM_DEPTH_DEF = 1024;
  localparam int unsigned ERR_W_DEF     = 11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_SETUP  = 3'd1,
    ST_WR_STROBE = 3'd2,
    ST_RD_ADDR   = 3'd3,
    ST_RD_CMP    = 3'd4,
    ST_DONE      = 3'd5
  } bist_state_e;

  // Test pattern: twice the address, optionally inverted; callers truncate to DATA_W.
  function automatic logic [31:0] pat(input logic [31:0] addr, input logic inv);
    logic [31:0] p;
    p = addr << 1;
    return inv ? ~p : p;
  endfunction

endpackage

// File: rtl/ram_bist_pattern.sv
// Combinational pattern generator used by both the write and compare paths.
module ram_bist_pattern
  import ram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              inv_i,
  output logic [DATA_W-1:0] pat_c_o
);

  // Truncation to DATA_W implements the mod 2^DATA_W.
  always_comb begin
    pat_c_o = DATA_W'(pat(32'(addr_i), inv_i));
  end

endmodule

// File: rtl/ram_bist_ctrl.sv
// RAM BIST controller: writes pat(a) to every word, reads back and compares.
// Optional macro RAM_BIST_PATTERN_SEL_EN adds pattern_sel for the inverted pattern.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int unsigned ERR_W     = ERR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef RAM_BIST_PATTERN_SEL_EN
  input  logic              pattern_sel,
`endif
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  error_cnt,
  output logic              first_err_vld,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  output logic              mem_cs,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  bist_state_e       state_q;
  logic [ADDR_W-1:0] counter_q, counter_d;
  logic              busy_q, done_q, pass_q, wr_q, cs_q;
  logic [ERR_W-1:0]  err_cnt_q;
  logic              fev_q;
  logic [ADDR_W-1:0] fea_q;
  logic [DATA_W-1:0] wdata_q;
  logic              pat_inv_q, pat_inv_d;
  logic [DATA_W-1:0] wr_pat, cmp_pat;
  logic              last_addr, mismatch;

  assign last_addr = (counter_q == LAST_ADDR);
  assign mismatch  = (mem_rdata != cmp_pat);

`ifdef RAM_BIST_PATTERN_SEL_EN
  // Pattern polarity is captured with an accepted start and held for the run.
  always_comb begin
    pat_inv_d = pat_inv_q;
    if (state_q == ST_IDLE && start) pat_inv_d = pattern_sel;
  end

  // Pattern polarity register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pat_inv_q <= 1'b0;
    else     pat_inv_q <= pat_inv_d;
  end
`else
  assign pat_inv_d = 1'b0;
  assign pat_inv_q = 1'b0;
`endif

  // Next address counter value; the write pattern is looked up from it so
  // mem_wdata is already valid when WR_SETUP is entered.
  always_comb begin
    counter_d = counter_q;
    case (state_q)
      ST_IDLE:      if (start) counter_d = '0;
      ST_WR_STROBE: counter_d = last_addr ? '0 : counter_q + ADDR_W'(1);
      ST_RD_CMP:    if (!last_addr) counter_d = counter_q + ADDR_W'(1);
      default:      counter_d = counter_q;
    endcase
  end

  ram_bist_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_pat (
    .addr_i  (counter_d),
    .inv_i   (pat_inv_d),
    .pat_c_o (wr_pat)
  );

  ram_bist_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cmp_pat (
    .addr_i  (counter_q),
    .inv_i   (pat_inv_q),
    .pat_c_o (cmp_pat)
  );

  // Sequencer with registered outputs; reset aborts a run and drops mem_wr at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      counter_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_cnt_q <= '0;
      fev_q     <= 1'b0;
      fea_q     <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      cs_q      <= 1'b0;
    end else begin
      counter_q <= counter_d;
      case (state_q)
        ST_IDLE: begin
          wr_q <= 1'b0;
          cs_q <= 1'b0;
          if (start) begin
            state_q   <= ST_WR_SETUP;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_cnt_q <= '0;
            fev_q     <= 1'b0;
            fea_q     <= '0;
            cs_q      <= 1'b1;
            wdata_q   <= wr_pat;
          end
        end
        ST_WR_SETUP: begin
          wr_q    <= 1'b1;
          state_q <= ST_WR_STROBE;
        end
        ST_WR_STROBE: begin
          wr_q <= 1'b0;
          if (last_addr) begin
            state_q <= ST_RD_ADDR;
          end else begin
            state_q <= ST_WR_SETUP;
            wdata_q <= wr_pat;
          end
        end
        ST_RD_ADDR: begin
          state_q <= ST_RD_CMP;
        end
        ST_RD_CMP: begin
          if (mismatch) begin
            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_W'(1);
            if (!fev_q) begin
              fev_q <= 1'b1;
              fea_q <= counter_q;
            end
          end
          if (last_addr) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            cs_q    <= 1'b0;
          end else begin
            state_q <= ST_RD_ADDR;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          pass_q  <= (err_cnt_q == '0);
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign error_cnt      = err_cnt_q;
  assign first_err_vld  = fev_q;
  assign first_err_addr = fea_q;
  assign mem_addr       = counter_q;
  assign mem_wdata      = wdata_q;
  assign mem_wr         = wr_q;
  assign mem_cs         = cs_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Self-checking bench for ram_bist_ctrl: RAM model with injectable stuck bits.
module tb_ram_bist_ctrl;

  localparam int DEPTH   = 1024;
  localparam int S_DEPTH = 64;
  localparam int LAT     = 4 * DEPTH + 1;
  localparam int S_LAT   = 4 * S_DEPTH + 1;

  logic clk;
  logic rst;
  logic start;
  logic busy, done, pass, first_err_vld, mem_wr, mem_cs;
  logic [10:0] error_cnt;
  logic [9:0]  first_err_addr, mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
`ifdef RAM_BIST_PATTERN_SEL_EN
  logic pattern_sel;
`endif

  logic        start_s;
  logic        busy_s, done_s, pass_s, fev_s, wr_s, cs_s;
  logic [3:0]  err_s;
  logic [9:0]  fea_s, addr_s;
  logic [7:0]  wdata_s, rdata_s;

  logic [7:0] ram   [DEPTH];
  logic [7:0] and_m [DEPTH];
  logic [7:0] or_m  [DEPTH];

  int tests = 0;
  int fails = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  ram_bist_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
`ifdef RAM_BIST_PATTERN_SEL_EN
    .pattern_sel    (pattern_sel),
`endif
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .error_cnt      (error_cnt),
    .first_err_vld  (first_err_vld),
    .first_err_addr (first_err_addr),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wr         (mem_wr),
    .mem_cs         (mem_cs),
    .mem_rdata      (mem_rdata)
  );

  ram_bist_ctrl #(.MEM_DEPTH(S_DEPTH), .ERR_W(4)) dut_sat (
    .clk            (clk),
    .rst            (rst),
    .start          (start_s),
`ifdef RAM_BIST_PATTERN_SEL_EN
    .pattern_sel    (1'b0),
`endif
    .busy           (busy_s),
    .done           (done_s),
    .pass           (pass_s),
    .error_cnt      (err_s),
    .first_err_vld  (fev_s),
    .first_err_addr (fea_s),
    .mem_addr       (addr_s),
    .mem_wdata      (wdata_s),
    .mem_wr         (wr_s),
    .mem_cs         (cs_s),
    .mem_rdata      (rdata_s)
  );

  assign rdata_s = 8'hFF;

  // RAM model: one write per strobe cycle, async read through the fault masks.
  always @(posedge clk) begin
    if (mem_cs && mem_wr) ram[mem_addr] <= mem_wdata;
  end

  always_comb begin
    mem_rdata = (ram[mem_addr] & and_m[mem_addr]) | or_m[mem_addr];
  end

  function automatic int ref_pat(input int a, input bit inv);
    int p;
    p = (2 * a) % 256;
    return inv ? (255 - p) : p;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < DEPTH; i++) begin
      and_m[i] = 8'hFF;
      or_m[i]  = 8'h00;
    end
  endtask

  task automatic add_fault(input int a, input int b, input bit s1);
    logic [7:0] m;
    m = 8'(1) << b;
    if (s1) or_m[a] = or_m[a] | m;
    else    and_m[a] = and_m[a] & ~m;
  endtask

  // Expected outcome of a whole run from the pattern rule and the fault masks.
  task automatic model_run(input bit inv, input int errmax, output int cnt, output int first);
    int w;
    logic [7:0] r;
    cnt = 0;
    first = -1;
    for (int a = 0; a < DEPTH; a++) begin
      w = ref_pat(a, inv);
      r = (8'(w) & and_m[a]) | or_m[a];
      if (int'(r) != w) begin
        if (cnt < errmax) cnt++;
        if (first < 0) first = a;
      end
    end
  endtask

  // Pulse start, then count clocks to done; optional extra start pulse mid-run.
  task automatic do_run(input int glitch_at, output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat  = 0;
    bcnt = busy ? 1 : 0;
    check("start_clears_done", int'(done), 0);
    while (!done && lat < LAT + 100) begin
      start = (glitch_at >= 0 && lat == glitch_at);
      @(posedge clk);
      #1;
      lat++;
      if (busy) bcnt++;
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string tag, input int lat, input int bcnt, input int exp_err,
                           input bit exp_vld, input int exp_first, input bit exp_pass);
    check({tag, ".latency"}, lat, LAT);
    check({tag, ".busy_cycles"}, bcnt, 4 * DEPTH);
    check({tag, ".done"}, int'(done), 1);
    check({tag, ".busy_after"}, int'(busy), 0);
    check({tag, ".error_cnt"}, int'(error_cnt), exp_err);
    check({tag, ".first_err_vld"}, int'(first_err_vld), int'(exp_vld));
    if (exp_vld) check({tag, ".first_err_addr"}, int'(first_err_addr), exp_first);
    check({tag, ".pass"}, int'(pass), int'(exp_pass));
  endtask

  typedef struct {
    int a0;
    int a1;
    int bitn;
    bit s1;
    int exp_err;
    bit exp_vld;
    int exp_first;
    bit exp_pass;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int lat, bcnt, cnt, first, n, wait_cyc;
    string tag;

    // a0/a1 = -1 means no fault; pat(9)=18 has bit 3 clear so only address 5 trips.
    vecs[0] = '{a0: -1,   a1: -1, bitn: 0, s1: 1'b0, exp_err: 0, exp_vld: 1'b0, exp_first: 0,    exp_pass: 1'b1};
    vecs[1] = '{a0: 5,    a1: 9,  bitn: 3, s1: 1'b0, exp_err: 1, exp_vld: 1'b1, exp_first: 5,    exp_pass: 1'b0};
    vecs[2] = '{a0: 5,    a1: 13, bitn: 3, s1: 1'b0, exp_err: 2, exp_vld: 1'b1, exp_first: 5,    exp_pass: 1'b0};
    vecs[3] = '{a0: -1,   a1: -1, bitn: 0, s1: 1'b0, exp_err: 0, exp_vld: 1'b0, exp_first: 0,    exp_pass: 1'b1};
    vecs[4] = '{a0: 0,    a1: -1, bitn: 0, s1: 1'b1, exp_err: 1, exp_vld: 1'b1, exp_first: 0,    exp_pass: 1'b0};
    vecs[5] = '{a0: 1023, a1: -1, bitn: 7, s1: 1'b0, exp_err: 1, exp_vld: 1'b1, exp_first: 1023, exp_pass: 1'b0};
    vecs[6] = '{a0: 128,  a1: -1, bitn: 0, s1: 1'b0, exp_err: 0, exp_vld: 1'b0, exp_first: 0,    exp_pass: 1'b1};

    rst = 1'b1;
    start = 1'b0;
    start_s = 1'b0;
`ifdef RAM_BIST_PATTERN_SEL_EN
    pattern_sel = 1'b0;
`endif
    clear_faults();
    repeat (3) @(negedge clk);
    check("reset.busy", int'(busy), 0);
    check("reset.done", int'(done), 0);
    check("reset.pass", int'(pass), 0);
    check("reset.error_cnt", int'(error_cnt), 0);
    check("reset.first_err_vld", int'(first_err_vld), 0);
    check("reset.mem_addr", int'(mem_addr), 0);
    check("reset.mem_wr", int'(mem_wr), 0);
    check("reset.mem_cs", int'(mem_cs), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven full runs; run 0 also has a stray start pulse at cycle 100.
    for (int i = 0; i < 7; i++) begin
      clear_faults();
      if (vecs[i].a0 >= 0) add_fault(vecs[i].a0, vecs[i].bitn, vecs[i].s1);
      if (vecs[i].a1 >= 0) add_fault(vecs[i].a1, vecs[i].bitn, vecs[i].s1);
      do_run((i == 0) ? 99 : -1, lat, bcnt);
      tag = $sformatf("vec%0d", i);
      check_run(tag, lat, bcnt, vecs[i].exp_err, vecs[i].exp_vld,
                vecs[i].exp_first, vecs[i].exp_pass);
      if (i == 0) begin
        check("vec0.ram300", int'(ram[300]), 88);
        check("vec0.ram1023", int'(ram[1023]), 254);
      end
      repeat (3) @(posedge clk);
      #1;
      check({tag, ".done_held"}, int'(done), 1);
      check({tag, ".cs_idle"}, int'(mem_cs), 0);
    end

    // Randomized stuck-at faults checked against the reference model.
    for (int r = 0; r < 3; r++) begin
      clear_faults();
      n = int'($urandom_range(1, 5));
      for (int k = 0; k < n; k++)
        add_fault(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)));
      model_run(1'b0, 2047, cnt, first);
      do_run(-1, lat, bcnt);
      check_run($sformatf("rand%0d", r), lat, bcnt, cnt, cnt > 0, first, cnt == 0);
    end

    // Reset while strobing address 17 aborts at once; controller then idles.
    clear_faults();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_cyc = 0;
    while (!(mem_wr && mem_addr == 10'd17) && wait_cyc < 200) begin
      @(posedge clk);
      #1;
      wait_cyc++;
    end
    check("rstmid.reached_addr17", int'(mem_wr && mem_addr == 10'd17), 1);
    rst = 1'b1;
    #1;
    check("rstmid.mem_wr", int'(mem_wr), 0);
    check("rstmid.mem_cs", int'(mem_cs), 0);
    check("rstmid.busy", int'(busy), 0);
    check("rstmid.done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("rstmid.idle_busy", int'(busy), 0);
    check("rstmid.idle_cs", int'(mem_cs), 0);
    check("rstmid.idle_done", int'(done), 0);
    check("rstmid.idle_addr", int'(mem_addr), 0);

    // Small instance with all-ones read data: counter saturates at 15.
    @(negedge clk);
    start_s = 1'b1;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    lat = 0;
    while (!done_s && lat < S_LAT + 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("sat.latency", lat, S_LAT);
    check("sat.error_cnt", int'(err_s), 15);
    check("sat.first_err_vld", int'(fev_s), 1);
    check("sat.first_err_addr", int'(fea_s), 0);
    check("sat.pass", int'(pass_s), 0);

`ifdef RAM_BIST_PATTERN_SEL_EN
    // Inverted pattern run.
    clear_faults();
    pattern_sel = 1'b1;
    model_run(1'b1, 2047, cnt, first);
    do_run(-1, lat, bcnt);
    pattern_sel = 1'b0;
    check_run("inv", lat, bcnt, cnt, cnt > 0, first, cnt == 0);
    check("inv.ram300", int'(ram[300]), 167);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
